// File: rtl/vga_wr_arb.sv
// rtl/vga_wr_arb.sv - two-requester write arbiter with frame-buffer clear sweep
//
// Ports:
//   CLK_25                 single clock, rising edge
//   Reset_N                asynchronous active-low reset
//   ClrStart / ClrData     one-cycle clear request and its fill value
//   ClrBusy                high while the clear sweep runs
//   ReqNValid/Addr/Data    requester N write request (N = 0, 1)
//   ReqNReady              combinational grant, transfer on Valid & Ready
//   WrEn/WrAddress/WrData  registered write port toward the VGA controller
module vga_wr_arb #(
  parameter int                ADDR_W   = 13,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] CLR_LAST = 13'h1FFF
) (
  input  logic              CLK_25,
  input  logic              Reset_N,
  input  logic              ClrStart,
  input  logic [DATA_W-1:0] ClrData,
  output logic              ClrBusy,
  input  logic              Req0Valid,
  input  logic [ADDR_W-1:0] Req0Addr,
  input  logic [DATA_W-1:0] Req0Data,
  output logic              Req0Ready,
  input  logic              Req1Valid,
  input  logic [ADDR_W-1:0] Req1Addr,
  input  logic [DATA_W-1:0] Req1Data,
  output logic              Req1Ready,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddress,
  output logic [DATA_W-1:0] WrData
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic              ptr, ptr_n;
  logic [DATA_W-1:0] fill, fill_n;
  logic              wr_en_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [DATA_W-1:0] wr_data_n;
  logic              gnt0, gnt1;

  always_ff @(posedge CLK_25 or negedge Reset_N) begin
    if (!Reset_N) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= 1'b0;
      fill      <= '0;
      WrEn      <= 1'b0;
      WrAddress <= '0;
      WrData    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ptr       <= ptr_n;
      fill      <= fill_n;
      WrEn      <= wr_en_n;
      WrAddress <= wr_addr_n;
      WrData    <= wr_data_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ptr_n     = ptr;
    fill_n    = fill;
    wr_en_n   = 1'b0;
    wr_addr_n = WrAddress;
    wr_data_n = WrData;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      IDLE: begin
        // A clear request outranks both requesters in the same cycle.
        if (ClrStart) begin
          fill_n  = ClrData;
          cnt_n   = '0;
          state_n = CLEAR;
        end else if (Req0Valid && (!Req1Valid || !ptr)) begin
          gnt0      = 1'b1;
          wr_en_n   = 1'b1;
          wr_addr_n = Req0Addr;
          wr_data_n = Req0Data;
          ptr_n     = 1'b1;
        end else if (Req1Valid) begin
          gnt1      = 1'b1;
          wr_en_n   = 1'b1;
          wr_addr_n = Req1Addr;
          wr_data_n = Req1Data;
          ptr_n     = 1'b0;
        end
      end
      CLEAR: begin
        wr_en_n   = 1'b1;
        wr_addr_n = cnt;
        wr_data_n = fill;
        // Stop on the last address instead of wrapping the counter.
        if (cnt == CLR_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Grants are gated by reset so nothing is offered while the block is held.
  assign Req0Ready = gnt0 & Reset_N;
  assign Req1Ready = gnt1 & Reset_N;
  assign ClrBusy   = (state == CLEAR);

endmodule

// File: tb/tb_vga_wr_arb.sv
// tb/tb_vga_wr_arb.sv - self-checking bench for vga_wr_arb
module tb_vga_wr_arb;

  localparam int          AW   = 13;
  localparam int          DW   = 32;
  localparam logic [12:0] LAST = 13'h7;

  logic          CLK_25 = 1'b0;
  logic          Reset_N;
  logic          ClrStart;
  logic [DW-1:0] ClrData;
  logic          ClrBusy;
  logic          Req0Valid, Req1Valid;
  logic [AW-1:0] Req0Addr, Req1Addr;
  logic [DW-1:0] Req0Data, Req1Data;
  logic          Req0Ready, Req1Ready;
  logic          WrEn;
  logic [AW-1:0] WrAddress;
  logic [DW-1:0] WrData;

  vga_wr_arb #(.ADDR_W(AW), .DATA_W(DW), .CLR_LAST(LAST)) dut (
    .CLK_25(CLK_25), .Reset_N(Reset_N),
    .ClrStart(ClrStart), .ClrData(ClrData), .ClrBusy(ClrBusy),
    .Req0Valid(Req0Valid), .Req0Addr(Req0Addr), .Req0Data(Req0Data), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1Addr(Req1Addr), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
    .WrEn(WrEn), .WrAddress(WrAddress), .WrData(WrData)
  );

  always #5 CLK_25 = ~CLK_25;

  int checks = 0;
  int errors = 0;

  // Reference model: pending clear addresses, round-robin preference,
  // fill value, and the write expected on the port after the next edge.
  logic [AW-1:0] clr_q[$];
  logic          m_ptr;
  logic [DW-1:0] m_fill;
  logic          e_en;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    clr_q.delete();
    m_ptr  = 1'b0;
    m_fill = '0;
    e_en   = 1'b0;
    e_addr = '0;
    e_data = '0;
  endtask

  task automatic drive_idle();
    ClrStart = 0; ClrData = '0;
    Req0Valid = 0; Req0Addr = '0; Req0Data = '0;
    Req1Valid = 0; Req1Addr = '0; Req1Data = '0;
  endtask

  // Called at a falling edge: check the write port against the previous
  // cycle's expectation, apply inputs, check grants, advance one cycle.
  task automatic step(input bit clr, input logic [DW-1:0] cd,
                      input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bit busy, g0, g1;
    chk("wr_en", WrEn, e_en);
    chk("wr_addr", WrAddress, e_addr);
    chk("wr_data", WrData, e_data);
    busy = (clr_q.size() != 0);
    chk("clr_busy", ClrBusy, busy);
    ClrStart = clr; ClrData = cd;
    Req0Valid = v0; Req0Addr = a0; Req0Data = d0;
    Req1Valid = v1; Req1Addr = a1; Req1Data = d1;
    #1;
    g0 = 0; g1 = 0; e_en = 0;
    if (busy) begin
      e_en = 1; e_addr = clr_q.pop_front(); e_data = m_fill;
    end else if (clr) begin
      m_fill = cd;
      for (int i = 0; i <= int'(LAST); i++) clr_q.push_back(AW'(i));
    end else if (v0 && (!v1 || !m_ptr)) begin
      g0 = 1; e_en = 1; e_addr = a0; e_data = d0; m_ptr = 1;
    end else if (v1) begin
      g1 = 1; e_en = 1; e_addr = a1; e_data = d1; m_ptr = 0;
    end
    chk("ready0", Req0Ready, g0);
    chk("ready1", Req1Ready, g1);
    @(posedge CLK_25);
    @(negedge CLK_25);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge CLK_25);
    Reset_N = 1'b0;
    drive_idle();
    Req0Valid = 1; Req1Valid = 1;
    repeat (2) @(negedge CLK_25);
    chk("rst_wr_en", WrEn, 0);
    chk("rst_wr_addr", WrAddress, 0);
    chk("rst_wr_data", WrData, 0);
    chk("rst_clr_busy", ClrBusy, 0);
    chk("rst_ready0", Req0Ready, 0);
    chk("rst_ready1", Req1Ready, 0);
    model_reset();
    drive_idle();
    Reset_N = 1'b1;
  endtask

  initial begin
    Reset_N = 1'b1;
    drive_idle();
    model_reset();
    #2;
    do_reset();

    // Quiet after reset.
    idle_steps(10);

    // Single requester 0 write, then nothing.
    step(0, '0, 1, 13'h1, 32'h3F333300, 0, '0, '0);
    idle_steps(2);

    // Both requesters held: alternating grants from a fresh pointer.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, '0, 1, 13'h51, 32'hA0, 1, 13'h52, 32'hB1);
    idle_steps(2);

    // Clear while requester 1 waits; it is served right after the sweep.
    step(1, 32'h0, 0, '0, '0, 1, 13'h123, 32'hCAFE);
    for (int i = 0; i < 9; i++) step(0, '0, 0, '0, '0, 1, 13'h123, 32'hCAFE);
    idle_steps(2);

    // Second ClrStart in the middle of a sweep is ignored.
    step(1, 32'h5A5A5A5A, 0, '0, '0, 0, '0, '0);
    idle_steps(3);
    step(1, 32'h11111111, 0, '0, '0, 0, '0, '0);
    idle_steps(8);

    // Asynchronous reset during a sweep, at count 3.
    step(1, 32'hDEADBEEF, 0, '0, '0, 0, '0, '0);
    idle_steps(3);
    #2;
    Reset_N = 1'b0;
    Req0Valid = 1;
    #1;
    chk("midrst_wr_en", WrEn, 0);
    chk("midrst_clr_busy", ClrBusy, 0);
    chk("midrst_ready0", Req0Ready, 0);
    model_reset();
    drive_idle();
    @(negedge CLK_25);
    Reset_N = 1'b1;
    idle_steps(6);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0, $urandom,
           1'($urandom_range(0, 1)), AW'($urandom), $urandom,
           1'($urandom_range(0, 1)), AW'($urandom), $urandom);
    end
    idle_steps(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
